// File: rtl/seq_mul16.sv
// Radix-2 shift-add multiplier: one partial-product add per clock, 16 iterations.
// Optional SEQ_MUL16_SIGNED_EN adds i_signed for two's-complement operands.
module seq_mul16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef SEQ_MUL16_SIGNED_EN
    input  logic                 i_signed,
`endif
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_m;
    logic [2*WIDTH-1:0]   r_p;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_accept;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_shift;
    logic [2*WIDTH-1:0]   w_final;
    logic [WIDTH-1:0]     w_load_m;
    logic [WIDTH-1:0]     w_load_b;

    assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Upper half plus multiplicand; carry-out lands in the new MSB so nothing is lost.
    assign w_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
    assign w_shift = r_p[0] ? {w_sum, r_p[WIDTH-1:1]} : {1'b0, r_p[2*WIDTH-1:1]};

`ifdef SEQ_MUL16_SIGNED_EN
    logic r_neg;
    logic w_load_neg;

    // Magnitude as unsigned: -(0x8000) stays 0x8000, which is the correct magnitude.
    assign w_load_m   = (i_signed && i_a[WIDTH-1]) ? (-i_a) : i_a;
    assign w_load_b   = (i_signed && i_b[WIDTH-1]) ? (-i_b) : i_b;
    assign w_load_neg = i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    assign w_final    = r_neg ? (-w_shift) : w_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= w_load_neg;
        end
    end
`else
    assign w_load_m = i_a;
    assign w_load_b = i_b;
    assign w_final  = w_shift;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_m      <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_m     <= w_load_m;
                        r_p     <= {{WIDTH{1'b0}}, w_load_b};
                        r_cnt   <= '0;
                        r_state <= S_MUL;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                S_MUL: begin
                    r_p   <= w_shift;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_result <= w_final;
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: tb/tb_seq_mul16.sv
// Directed self-checking bench for seq_mul16; signed vectors run when
// SEQ_MUL16_SIGNED_EN is defined.
module tb_seq_mul16;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;
`ifdef SEQ_MUL16_SIGNED_EN
    logic        i_signed;
`endif

    int n_checks = 0;
    int n_errors = 0;

    seq_mul16 #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef SEQ_MUL16_SIGNED_EN
        .i_signed (i_signed),
`endif
        .i_start  (i_start),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Start one operation, count busy cycles, check done pulse and result.
    task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp);
        int nbusy;
        @(negedge clk);
        i_a = a;
        i_b = b;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_a = 16'h5A5A;
        i_b = 16'hA5A5;
        nbusy = 0;
        while (o_busy && nbusy < 40) begin
            nbusy++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, nbusy, 16);
        check({tag, " done"}, {31'd0, o_done}, 32'd1);
        check({tag, " result"}, o_result, exp);
        @(negedge clk);
        check({tag, " done_width"}, {31'd0, o_done}, 32'd0);
        check({tag, " result_hold"}, o_result, exp);
    endtask

    initial begin
        int ndone;
        int gap;
        logic [31:0] seen;

        reset   = 1'b1;
        i_start = 1'b0;
        i_a     = '0;
        i_b     = '0;
`ifdef SEQ_MUL16_SIGNED_EN
        i_signed = 1'b0;
`endif
        @(negedge clk);
        check("reset busy", {31'd0, o_busy}, 32'd0);
        check("reset done", {31'd0, o_done}, 32'd0);
        check("reset result", o_result, 32'd0);
        reset = 1'b0;

        // 1: max operands, carry into MSB
        run_mul("t1 ffff*ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        repeat (5) @(negedge clk);
        check("t1 hold_idle", o_result, 32'hFFFE0001);

        // 2: zero operands still take 16 cycles
        run_mul("t2 1234*0", 16'h1234, 16'h0000, 32'h00000000);
        run_mul("t2 0*abcd", 16'h0000, 16'hABCD, 32'h00000000);
        run_mul("t2 1234*3", 16'h1234, 16'h0003, 32'h0000369C);

        // 3: start while busy is ignored
        @(negedge clk);
        i_a = 16'h00FF;
        i_b = 16'h0101;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        i_a = 16'hFFFF;
        i_b = 16'hFFFF;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        ndone = 0;
        seen = '0;
        for (int i = 0; i < 30; i++) begin
            if (o_done) begin
                ndone++;
                seen = o_result;
            end
            @(negedge clk);
        end
        check("t3 done_count", ndone, 1);
        check("t3 result", seen, 32'h0000FFFF);
        check("t3 idle", {31'd0, o_busy}, 32'd0);

        // 4: async reset mid-operation
        @(negedge clk);
        i_a = 16'h8000;
        i_b = 16'h8000;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t4 busy", {31'd0, o_busy}, 32'd0);
        check("t4 done", {31'd0, o_done}, 32'd0);
        check("t4 result", o_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_mul("t4 2*3", 16'h0002, 16'h0003, 32'h00000006);

        // 5: continuous start, back-to-back operations
        @(negedge clk);
        i_a = 16'h0010;
        i_b = 16'h0010;
        i_start = 1'b1;
        @(negedge clk);
        i_a = 16'h7FFF;
        i_b = 16'h0002;
        gap = 0;
        while (!o_done && gap < 40) begin
            gap++;
            @(negedge clk);
        end
        check("t5 first_done", {31'd0, o_done}, 32'd1);
        check("t5 first_result", o_result, 32'h00000100);
        @(negedge clk);
        check("t5 no_idle", {31'd0, o_busy}, 32'd1);
        i_start = 1'b0;
        gap = 1;
        while (!o_done && gap < 40) begin
            gap++;
            @(negedge clk);
        end
        check("t5 done_period", gap, 17);
        check("t5 second_result", o_result, 32'h0000FFFE);
        @(negedge clk);
        check("t5 back_idle", {31'd0, o_busy}, 32'd0);

`ifdef SEQ_MUL16_SIGNED_EN
        // 6: signed operands
        i_signed = 1'b1;
        run_mul("t6 -3*5", 16'hFFFD, 16'h0005, 32'hFFFFFFF1);
        run_mul("t6 min*min", 16'h8000, 16'h8000, 32'h40000000);
        run_mul("t6 7fff*-1", 16'h7FFF, 16'hFFFF, 32'hFFFF8001);
        i_signed = 1'b0;
        run_mul("t6 unsigned fffd*5", 16'hFFFD, 16'h0005, 32'h0004FFF1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_mul16.md
Name: seq_mul16

Overview:
- Sequential shift-add multiplier: 16x16-bit operands, 32-bit product, radix-2, one partial-product accumulation per clock.
- Sits directly upstream of the 32-bit carry-lookahead adder datapath. It drives the "upper-16 + 16-bit addend" accumulation each cycle, the same operation as cla32_16, and consumes the sum and carry-out.
- Used by the top-level ALU/controller for MUL operations.

Parameters:
- WIDTH, 16, operand width. The product is 2*WIDTH. The structural CLA datapath supports only 16; other values need a behavioural adder and are not required.

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- i_start  input  1  start request, sampled on rising edge
- i_a  input  16  multiplicand, captured when start is accepted
- i_b  input  16  multiplier, captured when start is accepted
- o_busy  output  1  high while iterating (MUL state)
- o_done  output  1  one-cycle pulse, product valid
- o_result  output  32  product, held until the next completion

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, o_busy=0, o_done=0, o_result=0, internal P=0, M=0, cnt=0.
- Internal registers:
  - M[15:0]: multiplicand.
  - P[31:0]: partial product / multiplier.
  - cnt[3:0]: iteration count.
- FSM states are IDLE, MUL, DONE.
  - IDLE: on i_start=1, load M<=i_a, P<={16'h0000,i_b}, cnt<=0, go to MUL. Otherwise stay.
  - MUL: each cycle:
    - If P[0]=1: {co,sum}=P[31:16]+M (17-bit result), then P<={co,sum,P[15:1]}.
    - Else: P<={1'b0,P[31:1]}.
    - cnt<=cnt+1.
    - When cnt==15, the shifted value is written to o_result (not P), and the state goes to DONE.
  - DONE: o_done=1 for this single cycle.
    - If i_start=1 here, it is accepted exactly as in IDLE and the state goes to MUL (back-to-back).
    - Otherwise go to IDLE.
- Latency: start sampled at edge k.
  - o_busy=1 from after edge k until edge k+16.
  - o_result updates at edge k+16.
  - o_done=1 between edges k+16 and k+17.
  - Fixed 16 iterations; no early termination.
- o_busy = (state==MUL). o_done = (state==DONE). Both are registered-state decodes and glitch-free.
- o_result changes only at the final MUL edge. It holds its value through IDLE and through any later operation until that operation completes.
- i_start while in MUL is ignored. i_a and i_b are don't-care except on the accepting edge.
- The adder carry-out is always captured into P[31]. A carry is never lost: 0xFFFF*0xFFFF must be exact.
- Reset asserted mid-operation aborts immediately to reset values. No partial result is ever presented.
- Operands of zero still take the full 16 iterations and give 0.

Optional Feature:
- Macro: SEQ_MUL16_SIGNED_EN.
- Defined:
  - Adds input port i_signed (1 bit), sampled with i_start.
  - When i_signed=1, operands are two's complement. The block latches their magnitudes (|i_a|, |i_b|, computed as 16-bit unsigned; |-32768|=0x8000 is valid) and a sign flag = i_a[15]^i_b[15].
  - The final write negates the 32-bit value when the sign flag is 1.
  - Latency is unchanged.
  - When i_signed=0, behaviour is identical to the unsigned block.
- Undefined: the port is absent and all operations are unsigned.

Test Plan:
1. Reset, then i_a=0xFFFF, i_b=0xFFFF, start pulse.
   - o_busy high for exactly 16 cycles, then o_done one cycle, o_result=0xFFFE0001.
   - o_result is unchanged thereafter with start low.
2. i_a=0x1234, i_b=0x0000, then i_a=0x0000, i_b=0xABCD.
   - Both give o_result=0x00000000 after 16 busy cycles.
   - Then i_a=0x1234, i_b=0x0003 gives 0x0000369C.
3. Start i_a=0x00FF, i_b=0x0101, then on busy cycle 5 pulse start with i_a=0xFFFF, i_b=0xFFFF.
   - Second start ignored; o_result=0x0000FFFF; only one o_done pulse.
4. Start i_a=0x8000, i_b=0x8000, assert reset asynchronously at busy cycle 8 (mid-cycle).
   - Immediately o_busy=0, o_done=0, o_result=0.
   - After release, a new start with 0x0002*0x0003 gives 0x00000006.
5. Hold i_start=1 continuously with operands changing each completion: 0x0010*0x0010, then 0x7FFF*0x0002.
   - o_done pulses every 17 cycles; results 0x00000100 then 0x0000FFFE; no idle cycle between operations.
6. With SEQ_MUL16_SIGNED_EN, i_signed=1:
   - -3*5 gives 0xFFFFFFF1.
   - -32768*-32768 gives 0x40000000.
   - 0x7FFF*-1 gives 0xFFFF8001.
   - With i_signed=0, 0xFFFD*0x0005 gives 0x0004FFF1.
